// File: rtl/conv1d_stream_layer.sv
// Streaming 1-D convolution layer: a KERNEL_HEIGHT-row sliding window over
// input rows of IN_CHANNELS words, N_FILTERS saturating fixed-point MACs in
// parallel, run-time writable weights/biases, one-entry output register.

// One filter: full-precision dot product over the window, bias, floor shift,
// saturate, optional ReLU.
module conv1d_filter #(
  parameter int TAPS      = 10,
  parameter int WORD_SIZE = 16,
  parameter int N_SIZE    = 12,
  parameter int RELU_EN   = 0
) (
  input  logic [TAPS-1:0][WORD_SIZE-1:0] x,
  input  logic [TAPS:0][WORD_SIZE-1:0]   w,
  output logic [WORD_SIZE-1:0]           y
);
  localparam int ACC_W = 2*WORD_SIZE + $clog2(TAPS);

  logic signed [WORD_SIZE-1:0]   wv, xv;
  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]       acc, shr;

  // Bias pre-scaled into the product's fixed-point format, then sum of products.
  always_comb begin
    wv   = w[TAPS];
    xv   = '0;
    prod = '0;
    acc  = ACC_W'(wv) <<< N_SIZE;
    for (int t = 0; t < TAPS; t++) begin
      wv   = w[t];
      xv   = x[t];
      prod = wv * xv;
      acc  = acc + ACC_W'(prod);
    end
    shr = acc >>> N_SIZE;
  end

  // Saturate to a signed word when the discarded upper bits are not a pure sign extension.
  always_comb begin
    if (shr[ACC_W-1] && !(&shr[ACC_W-1:WORD_SIZE-1]))
      y = {1'b1, {(WORD_SIZE-1){1'b0}}};
    else if (!shr[ACC_W-1] && (|shr[ACC_W-1:WORD_SIZE-1]))
      y = {1'b0, {(WORD_SIZE-1){1'b1}}};
    else
      y = shr[WORD_SIZE-1:0];
    if (RELU_EN != 0 && y[WORD_SIZE-1]) y = '0;
  end
endmodule

module conv1d_stream_layer #(
  parameter int INPUT_HEIGHT  = 64,
  parameter int IN_CHANNELS   = 2,
  parameter int KERNEL_HEIGHT = 5,
  parameter int STRIDE        = 1,
  parameter int N_FILTERS     = 8,
  parameter int WORD_SIZE     = 16,
  parameter int N_SIZE        = 12,
  parameter int RELU_EN       = 0,
  localparam int TAPS = KERNEL_HEIGHT*IN_CHANNELS,
  localparam int TW   = $clog2(TAPS+1),
  localparam int FW   = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1,
  localparam int AW   = FW + TW
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              valid_i,
  output logic                              yumi_o,
  input  logic [IN_CHANNELS*WORD_SIZE-1:0]  data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [N_FILTERS*WORD_SIZE-1:0]    data_o,
  output logic                              last_o,
  input  logic                              wen_i,
  input  logic [AW-1:0]                     waddr_i,
  input  logic [WORD_SIZE-1:0]              wdata_i,
  output logic                              busy_o
);
  localparam int RW    = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
  localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int N_OUT = (INPUT_HEIGHT - KERNEL_HEIGHT) / STRIDE + 1;
  localparam logic [RW-1:0] R_LAST  = RW'(INPUT_HEIGHT-1);
  localparam logic [RW-1:0] R_FIRST = RW'(KERNEL_HEIGHT-1);
  localparam logic [RW-1:0] R_FINAL = RW'(KERNEL_HEIGHT-1 + (N_OUT-1)*STRIDE);
  localparam logic [SW-1:0] S_MAX   = SW'(STRIDE-1);

  typedef enum logic [1:0] {eIDLE, eFILL, eRUN} state_t;
  state_t state, state_nxt;

  logic [RW-1:0] row;
  logic [SW-1:0] phase;   // rows since the last producing row, modulo STRIDE
  logic [KERNEL_HEIGHT-1:0][IN_CHANNELS-1:0][WORD_SIZE-1:0] win, win_nxt;
  logic [TAPS-1:0][WORD_SIZE-1:0]            taps;
  logic [N_FILTERS-1:0][TAPS:0][WORD_SIZE-1:0] wts;
  logic [N_FILTERS-1:0][WORD_SIZE-1:0]       res;
  logic [FW-1:0] wf;
  logic [TW-1:0] wt;
  logic producing, accept, last_row;

  assign producing = (row >= R_FIRST) && (phase == '0);
  assign yumi_o    = valid_i && (!producing || !valid_o || ready_i);
  assign accept    = yumi_o;
  assign last_row  = (row == R_LAST);
  assign wf        = waddr_i[AW-1:TW];
  assign wt        = waddr_i[TW-1:0];

  // Window as it will look once the presented row is shifted in; index 0 is oldest.
  always_comb begin
    win_nxt = win;
    for (int h = 0; h < KERNEL_HEIGHT-1; h++) win_nxt[h] = win[h+1];
    win_nxt[KERNEL_HEIGHT-1] = data_i;
  end
  assign taps = win_nxt;

  for (genvar f = 0; f < N_FILTERS; f++) begin : g_filt
    conv1d_filter #(
      .TAPS(TAPS), .WORD_SIZE(WORD_SIZE), .N_SIZE(N_SIZE), .RELU_EN(RELU_EN)
    ) u_filt (
      .x(taps), .w(wts[f]), .y(res[f])
    );
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= eIDLE;
    else            state <= state_nxt;
  end

  // Next state follows the index of the row being accepted.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (last_row)            state_nxt = eIDLE;
      else if (row >= R_FIRST) state_nxt = eRUN;
      else                     state_nxt = eFILL;
    end
  end

  // FSM outputs.
  always_comb begin
    busy_o = (state != eIDLE);
  end

  // Row counter, stride phase and window; all clear at the end of a frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      row   <= '0;
      phase <= '0;
      win   <= '0;
    end else if (accept) begin
      if (last_row) begin
        row   <= '0;
        phase <= '0;
        win   <= '0;
      end else begin
        row <= row + 1'b1;
        win <= win_nxt;
        if (producing)
          phase <= (STRIDE == 1) ? '0 : SW'(1);
        else if (row >= R_FIRST)
          phase <= (phase == S_MAX) ? '0 : phase + 1'b1;
      end
    end
  end

  // Weight/bias file, writable only between frames; out-of-range addresses dropped.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      wts <= '0;
    else if (wen_i && state == eIDLE && int'(wf) < N_FILTERS && int'(wt) <= TAPS)
      wts[wf][wt] <= wdata_i;
  end

  // One-entry output register; a new result may load in the same cycle the old one drains.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else if (accept && producing) begin
      valid_o <= 1'b1;
      last_o  <= (row == R_FINAL);
      data_o  <= res;
    end else if (ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv1d_stream_layer.sv
// Bench for conv1d_stream_layer: three instances (stride 1, stride 2, ReLU),
// directed rows, expected outputs queued at issue and popped by a monitor.
module tb_conv1d_stream_layer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       vi, rdy, wen;
  logic [2:0][15:0] din, wdata;
  logic [2:0][2:0]  waddr;
  wire  [2:0]       yumi, vo, lst, busy;
  wire  [2:0][31:0] dout;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    conv1d_stream_layer #(
      .INPUT_HEIGHT(8), .IN_CHANNELS(1), .KERNEL_HEIGHT(3),
      .STRIDE((d == 1) ? 2 : 1), .N_FILTERS(2), .WORD_SIZE(16),
      .N_SIZE(12), .RELU_EN((d == 2) ? 1 : 0)
    ) u_dut (
      .clk_i(clk), .reset_n_i(rst_n), .valid_i(vi[d]), .yumi_o(yumi[d]),
      .data_i(din[d]), .valid_o(vo[d]), .ready_i(rdy[d]), .data_o(dout[d]),
      .last_o(lst[d]), .wen_i(wen[d]), .waddr_i(waddr[d]), .wdata_i(wdata[d]),
      .busy_o(busy[d])
    );
  end

  typedef struct packed { logic [1:0] dut; logic [31:0] data; logic last; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pop on every handshake, and check the held output while stalled.
  logic [2:0]       hold_p = '0;
  logic [2:0][31:0] hold_d;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (hold_p[d] && rst_n) begin
        chk("hold_valid", 32'(vo[d]), 32'd1);
        chk("hold_data", dout[d], hold_d[d]);
      end
      hold_p[d] <= vo[d] && !rdy[d];
      hold_d[d] <= dout[d];
      if (vo[d] && rdy[d]) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: dut %0d data %h, none expected", d, dout[d]);
        end else begin
          mon_e = q.pop_front();
          chk("out_dut", 32'(d), 32'(mon_e.dut));
          chk("out_data", dout[d], mon_e.data);
          chk("out_last", 32'(lst[d]), 32'(mon_e.last));
        end
      end
    end
  end

  task automatic push(input int d, input logic [15:0] f1, input logic [15:0] f0, input logic l);
    exp_t e;
    e.dut = 2'(d); e.data = {f1, f0}; e.last = l;
    q.push_back(e);
  endtask

  task automatic push_same(input int d, input logic [15:0] f1, input logic [15:0] f0);
    for (int i = 0; i < 6; i++) push(d, f1, f0, i == 5);
  endtask

  task automatic wr(input int d, input int f, input int t, input logic [15:0] v);
    wen[d] = 1'b1; waddr[d] = {f[0], t[1:0]}; wdata[d] = v;
    @(posedge clk); #1;
    wen[d] = 1'b0;
  endtask

  task automatic set_w(input int d, input logic [15:0] w, input logic [15:0] b0, input logic [15:0] b1);
    for (int f = 0; f < 2; f++)
      for (int t = 0; t < 3; t++) wr(d, f, t, w);
    wr(d, 0, 3, b0);
    wr(d, 1, 3, b1);
  endtask

  // ey: 0/1 = required yumi on the first cycle the row is offered, 2 = don't care.
  task automatic send_row(input int d, input logic [15:0] x, input logic r, input int ey);
    int n = 0;
    logic got = 1'b0;
    vi[d] = 1'b1; din[d] = x; rdy[d] = r;
    while (!got) begin
      @(negedge clk);
      if (n == 0 && ey != 2) chk("yumi_first", 32'(yumi[d]), 32'(ey));
      got = yumi[d];
      @(posedge clk); #1;
      n++;
      if (!got && n > 50) begin
        n_chk++; n_fail++;
        $display("FAIL row_timeout: dut %0d row %h not accepted", d, x);
        got = 1'b1;
      end
    end
    vi[d] = 1'b0;
  endtask

  task automatic run_frame(input int d, input logic [7:0][15:0] rows);
    for (int i = 0; i < 8; i++) send_row(d, rows[i], 1'b1, 2);
  endtask

  task automatic drain(input int d);
    int n = 0;
    rdy[d] = 1'b1;
    while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("idle_busy", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0][15:0] ramp, ones, quarter;

  initial begin
    vi = '0; rdy = '1; wen = '0; din = '0; waddr = '0; wdata = '0;
    for (int i = 0; i < 8; i++) begin
      ramp[i]    = (i == 7) ? 16'h7FFF : 16'((i+1) * 16'h1000);
      ones[i]    = 16'h1000;
      quarter[i] = 16'((i+1) * 16'h0400);
    end
    repeat (2) @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", 32'(vo[d]), 32'd0);
      chk("rst_last", 32'(lst[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_data", dout[d], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unit weights over a ramp: 6.0, then saturation.
    set_w(0, 16'h1000, 16'h0000, 16'h0000);
    push(0, 16'h6000, 16'h6000, 1'b0);
    for (int i = 0; i < 5; i++) push(0, 16'h7FFF, 16'h7FFF, i == 4);
    run_frame(0, ramp);
    drain(0);

    // Half weights, filter 1 bias -1.0.
    set_w(0, 16'h0800, 16'h0000, 16'hF000);
    push_same(0, 16'h0800, 16'h1800);
    run_frame(0, ones);
    drain(0);

    // Backpressure on the first output of a ramp frame.
    push(0, 16'h2000, 16'h3000, 1'b0);
    push(0, 16'h3800, 16'h4800, 1'b0);
    push(0, 16'h5000, 16'h6000, 1'b0);
    push(0, 16'h6800, 16'h7800, 1'b0);
    push(0, 16'h7FFF, 16'h7FFF, 1'b0);
    push(0, 16'h7FFF, 16'h7FFF, 1'b1);
    for (int i = 0; i < 3; i++) send_row(0, ramp[i], 1'b0, 1);
    vi[0] = 1'b1; din[0] = ramp[3];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_yumi_low", 32'(yumi[0]), 32'd0);
      chk("bp_valid", 32'(vo[0]), 32'd1);
      @(posedge clk); #1;
    end
    send_row(0, ramp[3], 1'b1, 1);
    for (int i = 4; i < 8; i++) send_row(0, ramp[i], 1'b1, 2);
    drain(0);

    // Stride 2: outputs from rows 2, 4, 6; odd rows never stall.
    set_w(1, 16'h1000, 16'h0000, 16'h0000);
    push(1, 16'h1800, 16'h1800, 1'b0);
    push(1, 16'h3000, 16'h3000, 1'b0);
    push(1, 16'h4800, 16'h4800, 1'b1);
    send_row(1, quarter[0], 1'b1, 1);
    send_row(1, quarter[1], 1'b1, 1);
    send_row(1, quarter[2], 1'b0, 1);
    send_row(1, quarter[3], 1'b0, 1);
    send_row(1, quarter[4], 1'b1, 1);
    send_row(1, quarter[5], 1'b0, 1);
    send_row(1, quarter[6], 1'b1, 1);
    send_row(1, quarter[7], 1'b0, 1);
    drain(1);

    // -1.0 weights: ReLU clamps to zero, plain path gives -3.0.
    set_w(2, 16'hF000, 16'h0000, 16'h0000);
    push_same(2, 16'h0000, 16'h0000);
    run_frame(2, ones);
    drain(2);
    set_w(0, 16'hF000, 16'h0000, 16'h0000);
    push_same(0, 16'hD000, 16'hD000);
    run_frame(0, ones);
    drain(0);

    // Reset mid-frame, then writes outside idle are ignored.
    set_w(0, 16'h1000, 16'h0000, 16'h0000);
    push(0, 16'h3000, 16'h3000, 1'b0);
    push(0, 16'h3000, 16'h3000, 1'b0);
    for (int i = 0; i < 5; i++) send_row(0, ones[i], 1'b1, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(vo[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_data", dout[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_queue", 32'(q.size()), 32'd0);
    push_same(0, 16'h0000, 16'h0000);
    send_row(0, ones[0], 1'b1, 1);
    chk("frame_busy", 32'(busy[0]), 32'd1);
    set_w(0, 16'h1000, 16'h0000, 16'h0000);
    for (int i = 1; i < 8; i++) send_row(0, ones[i], 1'b1, 2);
    drain(0);
    set_w(0, 16'h1000, 16'h0000, 16'h0000);
    push_same(0, 16'h3000, 16'h3000);
    run_frame(0, ones);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv1d_stream_layer.md
Name: conv1d_stream_layer

Overview:
- Generalised streaming 1-D convolution layer. It accepts one input row per handshake; a row holds IN_CHANNELS words.
- It slides a KERNEL_HEIGHT-row window with a programmable STRIDE and computes N_FILTERS outputs in parallel. Arithmetic is saturating fixed point with optional ReLU.
- Weights and biases are held in a run-time writable register file, not in ROM.
- It sits between layers of the CNN datapath and uses the same demanding valid/yumi input and valid/ready output interfaces as the existing layers.

Parameters:
- INPUT_HEIGHT, 64, rows per frame.
- IN_CHANNELS, 2, words per input row (the kernel width).
- KERNEL_HEIGHT, 5, window rows; must be ≤ INPUT_HEIGHT.
- STRIDE, 1, row step between consecutive windows; must be ≥ 1.
- N_FILTERS, 8, output channels computed in parallel.
- WORD_SIZE, 16, bits per signed word.
- N_SIZE, 12, fractional bits.
- RELU_EN, 0, 1 = clamp negative outputs to 0.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  reset; asynchronous assert, active-low, synchronously deasserted externally.
- valid_i  in  1  input row valid.
- yumi_o  out  1  input row consumed this cycle.
- data_i  in  IN_CHANNELS*WORD_SIZE  input row; word c is channel c, signed.
- valid_o  out  1  output vector valid.
- ready_i  in  1  downstream ready.
- data_o  out  N_FILTERS*WORD_SIZE  one signed word per filter.
- last_o  out  1  qualifies data_o as the final window of the frame.
- wen_i  in  1  weight/bias write enable.
- waddr_i  in  AW  {filter index [clog2(N_FILTERS)], tap index [clog2(KERNEL_HEIGHT*IN_CHANNELS+1)]}.
- wdata_i  in  WORD_SIZE  weight/bias value, signed.
- busy_o  out  1  frame in progress (state != eIDLE).

Behaviour:
- **Reset.** Reset low sets the following:
  - valid_o=0, last_o=0, busy_o=0, data_o=0.
  - Row counter=0, window registers=0, all weights and biases=0, state=eIDLE.
  - Reset asserted mid-frame discards the partial frame and any pending output.
- **Weights.**
  - Tap t = h*IN_CHANNELS + c, where h=0 is the oldest row in the window.
  - Tap KERNEL_HEIGHT*IN_CHANNELS is the filter bias.
  - Writes take effect on the next edge only when state==eIDLE; writes in other states are ignored.
  - Out-of-range addresses are ignored.
- **FSM.**
  - eIDLE → eFILL on the first accepted row. If KERNEL_HEIGHT==1, go directly to eRUN.
  - eFILL → eRUN when the accepted row index reaches KERNEL_HEIGHT-1.
  - eRUN → eIDLE when row INPUT_HEIGHT-1 is accepted. The row counter and window clear; a pending output stays held until it handshakes.
- **Row counter r.**
  - Increments on each input handshake and wraps to 0 after INPUT_HEIGHT-1.
- **Producing row.**
  - A row produces an output iff r ≥ KERNEL_HEIGHT-1 and (r-(KERNEL_HEIGHT-1)) mod STRIDE == 0.
  - Outputs per frame = floor((INPUT_HEIGHT-KERNEL_HEIGHT)/STRIDE)+1.
  - last_o=1 on the output from the final producing row.
- **Input handshake.**
  - yumi_o = valid_i && (!producing_row || !valid_o || ready_i).
  - Non-producing rows are never stalled.
  - A producing row stalls while the output register is full and not draining.
- **Output.**
  - One-entry output register, 1-cycle latency: the producing row is accepted at edge k, and valid_o=1 after edge k with results from the window that includes that row.
  - data_o and last_o hold stable while valid_o && !ready_i.
  - valid_o clears after a handshake unless a new producing row is accepted in the same cycle; in that case the new result loads (back-to-back throughput of 1 per cycle).
- **Arithmetic, per filter.**
  - acc = Σ(w_t × x_t), using full 2*WORD_SIZE products and accumulator width 2*WORD_SIZE+clog2(KERNEL_HEIGHT*IN_CHANNELS).
  - Add bias<<N_SIZE.
  - Arithmetic shift right by N_SIZE (floor).
  - Saturate to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - If RELU_EN, negative results → 0.
- **Frame boundary.**
  - The first row of the next frame may be accepted in the cycle after the last row. The window never mixes frames.

Test Plan:
Config for all tests: IN_CHANNELS=1, KERNEL_HEIGHT=3, INPUT_HEIGHT=8, N_FILTERS=2, WORD_SIZE=16, N_SIZE=12, unless noted.
- **Basic window sums, STRIDE=1.**
  - Stimulus: all weights 0x1000, bias 0, rows 1.0..8.0 (0x1000..0x8000 clipped to 0x7FFF for 8.0), ready_i=1.
  - Response: 6 outputs, first 0x6000 (6.0), second 0x9000 saturates → 0x7FFF, last_o only on the 6th.
- **Fractional values and bias.**
  - Stimulus: weights 0x0800 (0.5), filter 1 bias 0xF000 (-1.0), rows 0x1000 each.
  - Response: filter0 = 0x1800, filter1 = 0x0800.
- **STRIDE=2.**
  - Stimulus: 8 rows.
  - Response: exactly 3 outputs, from rows 2, 4, 6; last_o on the row-6 result; yumi_o never drops for rows 3, 5, 7 even with ready_i=0.
- **Backpressure.**
  - Stimulus: ready_i=0 for 4 cycles at the first output.
  - Response: data_o stable; yumi_o=0 for the next producing row; no output lost or duplicated; total count 6.
- **RELU_EN=1.**
  - Stimulus: weights 0xF000 (-1.0), rows 0x1000.
  - Response: outputs 0x0000. With RELU_EN=0 the outputs are 0xD000.
- **Reset and write rules.**
  - Stimulus: reset_n_i pulsed low after row 4 accepted; then write weight mid-frame (ignored), complete a frame with the original write.
  - Response: valid_o=0 immediately on reset; the next frame starts at r=0; weights read back as 0 effect until rewritten in eIDLE.
